// File: rtl/spi_host_master.sv
// Mode-0 SPI initiator: serialises one 24-bit read/write frame per accepted command and,
// for reads, returns the 16-bit word the slave shifts back during the data phase.
module spi_host_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rwb,
  input  logic [6:0]  add,
  input  logic [15:0] data_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] data_out,
  output logic        csn,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StShift = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [7:0] HalfLast = 8'(CLK_DIV - 1);
  localparam logic [4:0] LastBit  = 5'd23;
  // Leaving bit index 7..22 produces rising edges 9..24, the data phase.
  localparam logic [4:0] FirstDataIdx = 5'd7;

  logic [2:0]  state_q, state_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [23:0] shift_q, shift_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] data_out_q, data_out_d;
  logic        rd_q, rd_d;
  logic        sclk_q, sclk_d;
  logic        half_end;

  assign half_end = (hcnt_q == HalfLast);

  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    rd_d       = rd_q;
    sclk_d     = sclk_q;
    data_out_d = data_out_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSetup;
          shift_d = {rwb, add, rwb ? 16'h0000 : data_in};
          rd_d    = rwb;
          hcnt_d  = 8'd0;
          bit_d   = 5'd0;
          rx_d    = 16'h0000;
        end
      end
      StSetup: begin
        if (half_end) begin
          state_d = StShift;
          hcnt_d  = 8'd0;
          sclk_d  = 1'b1;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      StShift: begin
        if (!half_end) begin
          hcnt_d = hcnt_q + 8'd1;
        end else begin
          hcnt_d = 8'd0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            // bit0 stays on mosi through the last low half and HOLD
            if (bit_q != LastBit) shift_d = {shift_q[22:0], 1'b0};
          end else if (bit_q == LastBit) begin
            state_d = StHold;
          end else begin
            sclk_d = 1'b1;
            bit_d  = bit_q + 5'd1;
            if (bit_q >= FirstDataIdx) rx_d = {rx_q[14:0], miso};
          end
        end
      end
      StHold: begin
        if (half_end) begin
          state_d = StDone;
          hcnt_d  = 8'd0;
          if (rd_q) data_out_d = rx_q;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      hcnt_q     <= 8'd0;
      bit_q      <= 5'd0;
      shift_q    <= 24'h000000;
      rx_q       <= 16'h0000;
      rd_q       <= 1'b0;
      sclk_q     <= 1'b0;
      data_out_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      rd_q       <= rd_d;
      sclk_q     <= sclk_d;
      data_out_q <= data_out_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign csn      = !((state_q == StSetup) || (state_q == StShift) || (state_q == StHold));
  assign sclk     = sclk_q;
  assign mosi     = csn ? 1'b0 : shift_q[23];
  assign data_out = data_out_q;

endmodule
